// File: rtl/frame_config_writer_pkg.sv
// Shared definitions for the frame configuration writer: header layout and FSM states.
package frame_config_writer_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hFA;

  // Header word: [31:24] sync, [23:16] column, [15:8] frame, [7:0] payload row count
  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] col;
    logic [7:0] frame;
    logic [7:0] nrows;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_STROBE  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns (col, frame, en) into a registered one-hot FrameStrobe; all-zero when en is low.
module frame_strobe_decoder #(
  parameter int NumberOfCols    = 16,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en,
  input  logic [7:0]                              col,
  input  logic [7:0]                              frame,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

  logic [NumberOfCols*MaxFramesPerCol-1:0] strobe_d, strobe_q;

  always_comb begin
    strobe_d = '0;
    for (int c = 0; c < NumberOfCols; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        if (en && col == 8'(c) && frame == 8'(f)) begin
          strobe_d[c*MaxFramesPerCol + f] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/frame_config_writer.sv
// Parses framed config words, loads FrameData rows, then pulses one FrameStrobe bit.
// s_ready is low only in the STROBE cycle and during reset; source must hold words meanwhile.
module frame_config_writer
  import frame_config_writer_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfRows    = 16,
  parameter int NumberOfCols    = 16
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  input  logic [FrameBitsPerRow-1:0]              s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic                                    err,
  output logic [15:0]                             frames_written
);

  state_e                     state_d, state_q;
  logic [7:0]                 col_d, col_q;
  logic [7:0]                 frame_d, frame_q;
  logic [7:0]                 n_d, n_q;
  logic [7:0]                 row_cnt_d, row_cnt_q;
  logic                       err_d, err_q;
  logic                       ready_d, ready_q;
  logic [15:0]                frames_d, frames_q;
  logic [FrameBitsPerRow-1:0] rows_d [NumberOfRows];
  logic [FrameBitsPerRow-1:0] rows_q [NumberOfRows];
  logic                       accept;
  logic                       strobe_en;
  hdr_t                       hdr;

  assign hdr = hdr_t'(s_data[31:0]);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    frame_d   = frame_q;
    n_d       = n_q;
    row_cnt_d = row_cnt_q;
    err_d     = err_q;
    frames_d  = frames_q;
    rows_d    = rows_q;
    accept    = s_valid && ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hdr.sync != SYNC_BYTE) begin
            err_d = 1'b1;
          end else if (hdr.col < 8'(NumberOfCols) && hdr.frame < 8'(MaxFramesPerCol) &&
                       hdr.nrows <= 8'(NumberOfRows)) begin
            col_d     = hdr.col;
            frame_d   = hdr.frame;
            n_d       = hdr.nrows;
            row_cnt_d = '0;
            state_d   = (hdr.nrows == 8'd0) ? ST_STROBE : ST_LOAD;
          end else begin
            // Bad target: still swallow the announced payload so the stream stays aligned
            err_d     = 1'b1;
            n_d       = hdr.nrows;
            row_cnt_d = '0;
            state_d   = (hdr.nrows == 8'd0) ? ST_IDLE : ST_DISCARD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          for (int r = 0; r < NumberOfRows; r++) begin
            if (row_cnt_q == 8'(r)) rows_d[r] = s_data;
          end
          row_cnt_d = row_cnt_q + 8'd1;
          if (row_cnt_q == n_q - 8'd1) state_d = ST_STROBE;
        end
      end
      ST_DISCARD: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + 8'd1;
          if (row_cnt_q == n_q - 8'd1) state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        frames_d = frames_q + 16'd1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d   = (state_d != ST_STROBE);
    strobe_en = (state_d == ST_STROBE);
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      frame_q   <= '0;
      n_q       <= '0;
      row_cnt_q <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      frames_q  <= '0;
      rows_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      frame_q   <= frame_d;
      n_q       <= n_d;
      row_cnt_q <= row_cnt_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      frames_q  <= frames_d;
      rows_q    <= rows_d;
    end
  end

  frame_strobe_decoder #(
    .NumberOfCols   (NumberOfCols),
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_strobe_dec (
    .clk   (UserCLK),
    .rst_n (resetn),
    .en    (strobe_en),
    .col   (col_d),
    .frame (frame_d),
    .strobe(FrameStrobe)
  );

  always_comb begin
    FrameData = '0;
    for (int r = 0; r < NumberOfRows; r++) begin
      FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[r];
    end
  end

  assign s_ready        = ready_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_STROBE);
  assign err            = err_q;
  assign frames_written = frames_q;

endmodule
